// File: rtl/player_pos_ctrl.sv
// Player grid-position controller: turns direction-key pulses into a bounded
// row/column position, rate-limits moves with a step cooldown, and runs the
// IDLE/PLAY/DONE game-phase FSM. All outputs come straight from registers.
module player_pos_ctrl #(
  parameter int unsigned ROWS       = 18,
  parameter int unsigned COLS       = 26,
  parameter int unsigned START_R    = 0,
  parameter int unsigned START_C    = 0,
  parameter int unsigned STEP_TICKS = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       game_over,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic [4:0] row,
  output logic [4:0] column,
  output logic       playing,
  output logic       moved,
  output logic [9:0] move_cnt
);

  // Wide enough for STEP_TICKS-1 even when STEP_TICKS is 1.
  localparam int unsigned CdW = $clog2(STEP_TICKS + 1);
  localparam logic [CdW-1:0] CdLoad = CdW'(STEP_TICKS - 1);
  localparam logic [4:0] RowMax   = 5'(ROWS - 1);
  localparam logic [4:0] ColMax   = 5'(COLS - 1);
  localparam logic [4:0] RowStart = 5'(START_R);
  localparam logic [4:0] ColStart = 5'(START_C);
  // Parked position never matches a legal trophy cell.
  localparam logic [4:0] Parked   = 5'd31;

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

  state_e         state_q, state_d;
  logic [4:0]     row_q, row_d;
  logic [4:0]     col_q, col_d;
  logic           moved_q, moved_d;
  logic [9:0]     cnt_q, cnt_d;
  logic [CdW-1:0] cd_q, cd_d;
  logic           pend_vld_q, pend_vld_d;
  dir_e           pend_dir_q, pend_dir_d;

  logic       key_any;
  dir_e       key_dir;
  logic       apply_vld;
  dir_e       apply_dir;
  logic       in_bounds;
  logic [4:0] tgt_row;
  logic [4:0] tgt_col;

  // Priority key decode: up > down > left > right.
  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    key_dir = DirRight;
    if (key_up) begin
      key_dir = DirUp;
    end else if (key_down) begin
      key_dir = DirDown;
    end else if (key_left) begin
      key_dir = DirLeft;
    end
  end

  // Pick the direction to apply (fresh key beats pending) and bound-check its target.
  always_comb begin
    apply_vld = key_any | pend_vld_q;
    apply_dir = key_any ? key_dir : pend_dir_q;
    tgt_row   = row_q;
    tgt_col   = col_q;
    in_bounds = 1'b0;
    unique case (apply_dir)
      DirUp: begin
        in_bounds = (row_q != 5'd0);
        tgt_row   = row_q - 5'd1;
      end
      DirDown: begin
        in_bounds = (row_q < RowMax);
        tgt_row   = row_q + 5'd1;
      end
      DirLeft: begin
        in_bounds = (col_q != 5'd0);
        tgt_col   = col_q - 5'd1;
      end
      DirRight: begin
        in_bounds = (col_q < ColMax);
        tgt_col   = col_q + 5'd1;
      end
    endcase
  end

  // Next-state logic for the phase FSM, position, cooldown and pending buffer.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    moved_d    = 1'b0;
    cnt_d      = cnt_q;
    cd_d       = cd_q;
    pend_vld_d = pend_vld_q;
    pend_dir_d = pend_dir_q;

    if (game_start) begin
      state_d    = StPlay;
      row_d      = RowStart;
      col_d      = ColStart;
      cnt_d      = 10'd0;
      cd_d       = '0;
      pend_vld_d = 1'b0;
    end else begin
      case (state_q)
        StPlay: begin
          if (game_over) begin
            state_d = StDone;
          end else if (cd_q != '0) begin
            cd_d = cd_q - CdW'(1);
            // Newest key during cooldown overwrites the buffer.
            if (key_any) begin
              pend_vld_d = 1'b1;
              pend_dir_d = key_dir;
            end
          end else if (apply_vld) begin
            // Consumed whether or not the move hits a wall.
            pend_vld_d = 1'b0;
            if (in_bounds) begin
              row_d   = tgt_row;
              col_d   = tgt_col;
              moved_d = 1'b1;
              cnt_d   = (cnt_q == 10'h3ff) ? cnt_q : cnt_q + 10'd1;
              cd_d    = CdLoad;
            end
          end
        end
        default: ;  // Idle and Done hold everything; keys are dropped.
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= Parked;
      col_q      <= Parked;
      moved_q    <= 1'b0;
      cnt_q      <= 10'd0;
      cd_q       <= '0;
      pend_vld_q <= 1'b0;
      pend_dir_q <= DirUp;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      moved_q    <= moved_d;
      cnt_q      <= cnt_d;
      cd_q       <= cd_d;
      pend_vld_q <= pend_vld_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  assign row      = row_q;
  assign column   = col_q;
  assign playing  = (state_q == StPlay);
  assign moved    = moved_q;
  assign move_cnt = cnt_q;

endmodule

// File: tb/tb_player_pos_ctrl.sv
// Scoreboard bench for player_pos_ctrl. Two instances share all inputs: one
// with STEP_TICKS=4, one with STEP_TICKS=1. Each driven cycle pushes the
// reference model's expected outputs; the sampled outputs are compared later.
module tb_player_pos_ctrl;

  localparam bit [3:0] KUp = 4'b1000;
  localparam bit [3:0] KDn = 4'b0100;
  localparam bit [3:0] KLf = 4'b0010;
  localparam bit [3:0] KRt = 4'b0001;

  typedef struct packed {
    bit       rst;
    bit       start;
    bit       over;
    bit [3:0] keys;  // {up, down, left, right}
  } stim_t;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] c;
    logic       pl;
    logic       mv;
    logic [9:0] cnt;
  } obs_t;

  typedef struct {
    int st;  // 0 idle, 1 play, 2 done
    int r;
    int c;
    bit mv;
    int cnt;
    int cd;
    bit pv;
    int pd;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b0, game_start = 1'b0, game_over = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [4:0] row4, col4, row1, col1;
  logic       playing4, moved4, playing1, moved1;
  logic [9:0] cnt4, cnt1;

  int n_run = 0;
  int n_fail = 0;
  int n_print = 0;

  mdl_t m4, m1;
  obs_t exp4_q[$], act4_q[$], exp1_q[$], act1_q[$];

  always #5 clk = ~clk;

  player_pos_ctrl #(.STEP_TICKS(4)) dut4 (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .row(row4), .column(col4), .playing(playing4), .moved(moved4), .move_cnt(cnt4)
  );

  player_pos_ctrl #(.STEP_TICKS(1)) dut1 (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .row(row1), .column(col1), .playing(playing1), .moved(moved1), .move_cnt(cnt1)
  );

  function automatic stim_t mk(bit r, bit st, bit ov, bit [3:0] k);
    stim_t s;
    s.rst = r; s.start = st; s.over = ov; s.keys = k;
    return s;
  endfunction

  // Reference behaviour of one clock edge, on an 18x26 field starting at (0,0).
  function automatic mdl_t model_step(mdl_t m, stim_t s, int step);
    mdl_t n = m;
    int kd, d, tr, tc;
    kd = s.keys[3] ? 0 : s.keys[2] ? 1 : s.keys[1] ? 2 : s.keys[0] ? 3 : -1;
    n.mv = 1'b0;
    if (s.rst) begin
      n.st = 0; n.r = 31; n.c = 31; n.cnt = 0; n.cd = 0; n.pv = 1'b0;
    end else if (s.start) begin
      n.st = 1; n.r = 0; n.c = 0; n.cnt = 0; n.cd = 0; n.pv = 1'b0;
    end else if (m.st == 1 && s.over) begin
      n.st = 2;
    end else if (m.st == 1) begin
      if (m.cd != 0) begin
        n.cd = m.cd - 1;
        if (kd >= 0) begin n.pv = 1'b1; n.pd = kd; end
      end else begin
        d = (kd >= 0) ? kd : (m.pv ? m.pd : -1);
        n.pv = 1'b0;
        if (d >= 0) begin
          tr = m.r; tc = m.c;
          case (d)
            0: tr = tr - 1;
            1: tr = tr + 1;
            2: tc = tc - 1;
            default: tc = tc + 1;
          endcase
          if (tr >= 0 && tr < 18 && tc >= 0 && tc < 26) begin
            n.r = tr; n.c = tc; n.mv = 1'b1; n.cd = step - 1;
            if (m.cnt < 1023) n.cnt = m.cnt + 1;
          end
        end
      end
    end
    return n;
  endfunction

  function automatic obs_t obs_of(mdl_t m);
    obs_t o;
    o.r = 5'(m.r); o.c = 5'(m.c); o.pl = (m.st == 1); o.mv = m.mv; o.cnt = 10'(m.cnt);
    return o;
  endfunction

  // Drive one cycle of stimulus, push expectations, capture outputs after the edge.
  task automatic drive(stim_t s);
    rst = s.rst; game_start = s.start; game_over = s.over;
    {key_up, key_down, key_left, key_right} = s.keys;
    m4 = model_step(m4, s, 4);
    m1 = model_step(m1, s, 1);
    exp4_q.push_back(obs_of(m4));
    exp1_q.push_back(obs_of(m1));
    @(posedge clk);
    #1;
    act4_q.push_back({row4, col4, playing4, moved4, cnt4});
    act1_q.push_back({row1, col1, playing1, moved1, cnt1});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(mk(0, 0, 0, 4'b0));
  endtask

  task automatic test_reset;
    obs_t e, a;
    drive(mk(1, 0, 0, 4'b0));
    drive(mk(1, 0, 0, 4'b0));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.r !== 5'd31 || a.c !== 5'd31 || a.pl !== 1'b0 || a.mv !== 1'b0 || a.cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_values: got %h required r=1f c=1f pl=0 mv=0 cnt=0", a);
    end
    drive(mk(0, 0, 0, KRt)); drive(mk(0, 0, 0, KDn)); drive(mk(0, 0, 0, KUp | KLf));
    idle(2);
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.r !== 5'd31 || a.c !== 5'd31 || a.mv !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_keys_dropped: got r=%0d c=%0d mv=%0b required 31 31 0", a.r, a.c, a.mv);
    end
    while (exp4_q.size() > 0) begin
      e = exp4_q.pop_front(); a = act4_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL reset_sb4: got %h required %h", a, e); end
      e = exp1_q.pop_front(); a = act1_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL reset_sb1: got %h required %h", a, e); end
    end
  endtask

  task automatic test_basic_moves;
    obs_t e, a;
    drive(mk(0, 1, 0, 4'b0));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.pl !== 1'b1 || a.r !== 5'd0 || a.c !== 5'd0) begin
      n_fail++;
      $display("FAIL start_latency: got pl=%0b r=%0d c=%0d required 1 0 0", a.pl, a.r, a.c);
    end
    drive(mk(0, 0, 0, KRt));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.c !== 5'd1 || a.mv !== 1'b1 || a.cnt !== 10'd1) begin
      n_fail++;
      $display("FAIL first_right: got c=%0d mv=%0b cnt=%0d required 1 1 1", a.c, a.mv, a.cnt);
    end
    idle(3);
    drive(mk(0, 0, 0, KDn));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.r !== 5'd1 || a.cnt !== 10'd2 || a.mv !== 1'b1) begin
      n_fail++;
      $display("FAIL down_after_cd: got r=%0d cnt=%0d mv=%0b required 1 2 1", a.r, a.cnt, a.mv);
    end
    idle(2);
    while (exp4_q.size() > 0) begin
      e = exp4_q.pop_front(); a = act4_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL basic_sb4: got %h required %h", a, e); end
      e = exp1_q.pop_front(); a = act1_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL basic_sb1: got %h required %h", a, e); end
    end
  endtask

  task automatic test_wall;
    obs_t e, a;
    drive(mk(0, 1, 0, 4'b0));
    drive(mk(0, 0, 0, KLf));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.c !== 5'd0 || a.r !== 5'd0 || a.mv !== 1'b0 || a.cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL wall_left: got r=%0d c=%0d mv=%0b cnt=%0d required 0 0 0 0",
               a.r, a.c, a.mv, a.cnt);
    end
    drive(mk(0, 0, 0, KUp));
    drive(mk(0, 0, 0, KRt));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.c !== 5'd1 || a.mv !== 1'b1 || a.cnt !== 10'd1) begin
      n_fail++;
      $display("FAIL after_wall_right: got c=%0d mv=%0b cnt=%0d required 1 1 1", a.c, a.mv, a.cnt);
    end
    idle(4);
    while (exp4_q.size() > 0) begin
      e = exp4_q.pop_front(); a = act4_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL wall_sb4: got %h required %h", a, e); end
      e = exp1_q.pop_front(); a = act1_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL wall_sb1: got %h required %h", a, e); end
    end
  endtask

  task automatic test_pending_priority;
    obs_t e, a;
    drive(mk(0, 1, 0, 4'b0));
    drive(mk(0, 0, 0, KRt));
    drive(mk(0, 0, 0, KDn));
    idle(2);
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.r !== 5'd0 || a.mv !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_early: got r=%0d mv=%0b required 0 0", a.r, a.mv);
    end
    idle(1);
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.r !== 5'd1 || a.c !== 5'd1 || a.mv !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_applied: got r=%0d c=%0d mv=%0b required 1 1 1", a.r, a.c, a.mv);
    end
    idle(3);
    for (int i = 0; i < 4; i++) begin drive(mk(0, 0, 0, KRt)); idle(3); end
    for (int i = 0; i < 4; i++) begin drive(mk(0, 0, 0, KDn)); idle(3); end
    drive(mk(0, 0, 0, KUp | KLf));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.r !== 5'd4 || a.c !== 5'd5) begin
      n_fail++;
      $display("FAIL up_left_priority: got r=%0d c=%0d required 4 5", a.r, a.c);
    end
    idle(4);
    while (exp4_q.size() > 0) begin
      e = exp4_q.pop_front(); a = act4_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL pend_sb4: got %h required %h", a, e); end
      e = exp1_q.pop_front(); a = act1_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL pend_sb1: got %h required %h", a, e); end
    end
  endtask

  task automatic test_game_over;
    obs_t e, a;
    drive(mk(0, 1, 0, 4'b0));
    for (int i = 0; i < 3; i++) begin drive(mk(0, 0, 0, KDn)); idle(3); end
    for (int i = 0; i < 7; i++) begin drive(mk(0, 0, 0, KRt)); idle(3); end
    drive(mk(0, 0, 1, KRt));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.pl !== 1'b0 || a.r !== 5'd3 || a.c !== 5'd7 || a.mv !== 1'b0) begin
      n_fail++;
      $display("FAIL game_over: got pl=%0b r=%0d c=%0d mv=%0b required 0 3 7 0",
               a.pl, a.r, a.c, a.mv);
    end
    for (int i = 0; i < 20; i++) drive(mk(0, 0, 0, 4'($urandom_range(0, 15))));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.r !== 5'd3 || a.c !== 5'd7 || a.cnt !== 10'd10) begin
      n_fail++;
      $display("FAIL done_frozen: got r=%0d c=%0d cnt=%0d required 3 7 10", a.r, a.c, a.cnt);
    end
    drive(mk(0, 1, 0, 4'b0));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.pl !== 1'b1 || a.r !== 5'd0 || a.c !== 5'd0 || a.cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL restart: got pl=%0b r=%0d c=%0d cnt=%0d required 1 0 0 0",
               a.pl, a.r, a.c, a.cnt);
    end
    drive(mk(0, 0, 0, KRt));
    drive(mk(0, 1, 1, 4'b0));
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.pl !== 1'b1 || a.c !== 5'd0) begin
      n_fail++;
      $display("FAIL start_over_same: got pl=%0b c=%0d required 1 0", a.pl, a.c);
    end
    idle(2);
    while (exp4_q.size() > 0) begin
      e = exp4_q.pop_front(); a = act4_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL over_sb4: got %h required %h", a, e); end
      e = exp1_q.pop_front(); a = act1_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL over_sb1: got %h required %h", a, e); end
    end
  endtask

  task automatic test_saturation_reset;
    obs_t e, a;
    drive(mk(0, 1, 0, 4'b0));
    for (int i = 0; i < 1100; i++) drive(mk(0, 0, 0, (i % 2 == 0) ? KRt : KLf));
    a = act1_q[act1_q.size()-1];
    n_run++;
    if (a.cnt !== 10'd1023 || a.c !== 5'd0) begin
      n_fail++;
      $display("FAIL saturation: got cnt=%0d c=%0d required 1023 0", a.cnt, a.c);
    end
    idle(4);
    drive(mk(0, 0, 0, KDn));
    drive(mk(0, 0, 0, KRt));
    drive(mk(1, 0, 0, 4'b0));
    drive(mk(1, 0, 0, 4'b0));
    idle(5);
    a = act4_q[act4_q.size()-1];
    n_run++;
    if (a.r !== 5'd31 || a.c !== 5'd31 || a.pl !== 1'b0 || a.mv !== 1'b0 || a.cnt !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_mid_game: got %h required r=1f c=1f pl=0 mv=0 cnt=0", a);
    end
    while (exp4_q.size() > 0) begin
      e = exp4_q.pop_front(); a = act4_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL sat_sb4: got %h required %h", a, e); end
      e = exp1_q.pop_front(); a = act1_q.pop_front(); n_run++;
      if (a !== e) begin n_fail++; if (n_print++ < 40) $display("FAIL sat_sb1: got %h required %h", a, e); end
    end
  endtask

  initial begin
    m4 = '{st: 0, r: 31, c: 31, mv: 1'b0, cnt: 0, cd: 0, pv: 1'b0, pd: 0};
    m1 = m4;
    @(posedge clk);
    #1;
    test_reset();
    test_basic_moves();
    test_wall();
    test_pending_priority();
    test_game_over();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/player_pos_ctrl.md
# player_pos_ctrl

Grid-position controller for the player token. It turns one-cycle direction-key pulses from the keyboard decoder into a bounded `row`/`column` position on the 18×26 play field, and rate-limits moves with a step cooldown. It runs a small IDLE/PLAY/DONE game-phase FSM. Its `row`/`column` outputs drive the trophy-collection logic directly; its `playing` flag gates that logic's position resampling.

## Interface
- `ROWS`, default 18: row count; legal rows are 0..ROWS-1.
- `COLS`, default 26: column count; legal columns are 0..COLS-1.
- `START_R`, default 0: row loaded on game start.
- `START_C`, default 0: column loaded on game start.
- `STEP_TICKS`, default 5_000_000: minimum number of cycles between accepted moves; must be ≥1.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `game_start` input 1: one-cycle pulse that starts or restarts a game.
- `game_over` input 1: one-cycle pulse that ends the game.
- `key_up`, `key_down`, `key_left`, `key_right` input 1 each: one-cycle direction pulses.
- `row` output 5: current player row; 31 while parked.
- `column` output 5: current player column; 31 while parked.
- `playing` output 1: high in PLAY.
- `moved` output 1: one-cycle pulse in the cycle after a position change.
- `move_cnt` output 10: number of accepted moves this game; saturates at 1023.

## Operation
- **FSM states**
  - IDLE (reset state): position parked at (31,31), which never matches a legal trophy cell.
  - PLAY: keys are accepted.
  - DONE: position frozen at its last value; keys are ignored.
- **Transitions**
  - Any state → PLAY on `game_start`.
  - PLAY → DONE on `game_over`.
  - DONE stays in DONE until `game_start`.
  - `game_start` has priority over `game_over` in the same cycle.
- **Entry into PLAY** (including a restart from PLAY): row=START_R, column=START_C, move_cnt=0, cooldown=0, pending buffer cleared.
- **Key decode:** when several keys are high in one cycle, priority is up > down > left > right. Up decrements row, down increments row, left decrements column, right increments column.
- **Acceptance:** in PLAY with cooldown==0, a decoded direction (a new key, otherwise the pending one) is applied.
  - Target in bounds: update the position, pulse `moved`, increment move_cnt (saturating), and load cooldown with STEP_TICKS-1.
  - Target out of bounds (row 0 up, row ROWS-1 down, column 0 left, column COLS-1 right): no position change, no `moved` pulse, move_cnt unchanged, cooldown not loaded. The pending entry is consumed.
- **Pending buffer:** one entry deep, holding a direction and a valid bit.
  - A key arriving while cooldown≠0 overwrites the buffer, so the newest key wins.
  - The buffer is applied in the first cycle with cooldown==0. A fresh key in that same cycle takes precedence and clears the buffer.
  - Keys in IDLE or DONE are dropped and never buffered.
- **Cooldown:** decrements by 1 per cycle while nonzero, in PLAY only. It is held in DONE and cleared on game start.
- **Arithmetic:** all position arithmetic is 5-bit, and bounds are checked before the update, so no wrap-around ever reaches `row`/`column`.

## Timing
- **Reset values:** state=IDLE, row=31, column=31, playing=0, moved=0, move_cnt=0, cooldown=0, pending invalid.
- **Start latency:** `game_start` sampled at edge N → `playing`=1 and position=(START_R,START_C) from edge N.
- **Move latency:** a key sampled at edge N with cooldown==0 → new position and `moved`=1 after edge N (one-cycle latency). `moved` drops after edge N+1 unless another move occurs.
- **Move rate:** the next move is accepted no earlier than edge N+STEP_TICKS. With STEP_TICKS=1 a move can be taken every cycle.
- **Game over:** `game_over` at edge N → `playing`=0 after edge N. Position is unchanged. A key in the same cycle is ignored.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst` for 2 cycles → row=31, column=31, playing=0, move_cnt=0, moved=0; key pulses in IDLE do not change any output.
- **Basic moves:** STEP_TICKS=4. `game_start`, then `key_right` → column 0→1 one cycle later with `moved` pulse and move_cnt=1. `key_down` 4 cycles later → row=1, move_cnt=2.
- **Wall and cooldown:** at (0,0), `key_left` → position stays (0,0), no `moved`, move_cnt=0. An immediately following `key_right` is accepted.
- **Pending and priority:** STEP_TICKS=4. Press `key_right`, then `key_down` in the next cycle (cooldown active) → the down move is applied exactly 4 cycles after the first. Separately, `key_up` and `key_left` in the same cycle at (5,5) → (4,5).
- **Game over and restart:** from (3,7), `game_over` → playing=0 and keys ignored for 20 cycles. `game_start` → playing=1, position (START_R,START_C), move_cnt=0. `game_start` and `game_over` in the same cycle → PLAY.
- **Saturation and reset mid-game:** STEP_TICKS=1, alternating right/left for 1100 moves → move_cnt=1023. Then `rst` mid-cooldown → all reset values and the pending move is lost.
